// File: rtl/cas_scheduler_if.sv
// Handshake bundle between the ACT stage, the CAS scheduler and the command bus.
// Both channels use valid/ready: a transfer happens in any cycle where valid
// and ready are both high. Once valid is raised, the sender holds valid and
// payload stable until the transfer. Ready may depend on anything.
interface cas_scheduler_if #(
  parameter int ADDR_W = 14
);
  logic              act_valid;
  logic              act_ready;
  logic [1:0]        act_rw;
  logic [ADDR_W-1:0] act_addr;
  logic              cas_valid;
  logic              cas_ready;
  logic [1:0]        cas_rw;
  logic [ADDR_W-1:0] cas_addr;

  // ACT-stage / downstream side
  modport master (
    output act_valid, act_rw, act_addr, cas_ready,
    input  act_ready, cas_valid, cas_rw, cas_addr
  );

  // scheduler side
  modport slave (
    input  act_valid, act_rw, act_addr, cas_ready,
    output act_ready, cas_valid, cas_rw, cas_addr
  );
endinterface

// File: rtl/cas_scheduler.sv
// CAS issue scheduler: queues activated requests, ages each from its ACT and
// issues READ/WRITE CAS commands in order while honouring tRCD, tCCD and the
// read/write turnaround gaps.
module cas_scheduler #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 14,
  parameter int TRCD   = 11,
  parameter int TWTR   = 6
) (
  input  logic             clock_t,
  input  logic             reset,
  cas_scheduler_if.slave   bus,
  input  logic [CNT_W-1:0] tCCD,
  input  logic [CNT_W-1:0] CL,
  input  logic [CNT_W-1:0] CWL,
  input  logic [CNT_W-1:0] BL,
  output logic             cas_idle,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0]       RW_READ  = 2'b00;
  localparam logic [1:0]       RW_WRITE = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] AGE_MIN  = (TRCD > 1) ? CNT_W'(TRCD - 1) : '0;
  localparam logic [CNT_W:0]   TWTR_C   = (CNT_W + 1)'(TWTR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   mem [DEPTH];   // {is_write, addr}
  logic [CNT_W-1:0]  age [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_n;
  logic [CNT_W-1:0]  since_cas;
  logic              last_wr;
  logic [1:0]        cas_rw_q;
  logic [ADDR_W-1:0] cas_addr_q;

  logic             push, hs;
  logic             head_wr;
  logic [CNT_W-1:0] head_age;
  logic [CNT_W:0]   half_bl, ccd, rw_term, wr_term, gap;
  logic             spacing_ok, eligible;

  assign bus.act_ready = (count != (AW + 1)'(DEPTH));
  assign bus.cas_valid = (state == ST_ISSUE);
  assign bus.cas_rw    = cas_rw_q;
  assign bus.cas_addr  = cas_addr_q;
  assign state_dbg     = state;

  assign push     = bus.act_valid && bus.act_ready;
  assign hs       = bus.cas_valid && bus.cas_ready;
  assign head_wr  = mem[rd_ptr][ADDR_W];
  assign head_age = age[rd_ptr];
  assign count_n  = count + (AW + 1)'(push) - (AW + 1)'(hs);

  // Required CAS-to-CAS gap for the head entry given the last issued direction.
  always_comb begin
    half_bl = {1'b0, BL} >> 1;
    ccd     = {1'b0, tCCD};
    rw_term = ((CL > CWL) ? ({1'b0, CL} - {1'b0, CWL}) : '0) + half_bl + (CNT_W + 1)'(2);
    wr_term = {1'b0, CWL} + half_bl + TWTR_C;
    gap     = ccd;
    if (head_wr != last_wr) begin
      if (head_wr) gap = (rw_term > ccd) ? rw_term : ccd;
      else         gap = (wr_term > ccd) ? wr_term : ccd;
    end
    spacing_ok = (gap == '0) || ({1'b0, since_cas} >= (gap - (CNT_W + 1)'(1)));
    eligible   = (count != '0) && (head_age >= AGE_MIN) && spacing_ok;
  end

  // Next-state logic; after a handshake always pass through WAIT so the
  // freshly cleared spacing counter is re-evaluated for the new head.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (count != '0) state_n = eligible ? ST_ISSUE : ST_WAIT;
      ST_WAIT:  if (eligible) state_n = ST_ISSUE;
      ST_ISSUE: if (bus.cas_ready) state_n = (count_n == '0) ? ST_IDLE : ST_WAIT;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_t) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {(bus.act_rw == RW_WRITE), bus.act_addr};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (hs) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  // Per-entry age since ACT; a new entry is written as 1 because its ACT
  // cycle has already elapsed by the time the register is visible.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (age[i] != CNT_MAX) age[i] <= age[i] + CNT_W'(1);
      if (push) age[wr_ptr] <= CNT_W'(1);
    end
  end

  // Spacing counter and last direction; counts from the handshake cycle,
  // frozen while a CAS is stalled, saturated out of reset.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      since_cas <= CNT_MAX;
      last_wr   <= 1'b0;
    end else if (hs) begin
      since_cas <= CNT_W'(1);
      last_wr   <= head_wr;
    end else if (!bus.cas_valid && since_cas != CNT_MAX) begin
      since_cas <= since_cas + CNT_W'(1);
    end
  end

  // Registered CAS payload, captured from the head on entry to ISSUE.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      cas_rw_q   <= RW_READ;
      cas_addr_q <= '0;
    end else if (state_n == ST_ISSUE && state != ST_ISSUE) begin
      cas_rw_q   <= head_wr ? RW_WRITE : RW_READ;
      cas_addr_q <= mem[rd_ptr][ADDR_W-1:0];
    end
  end

  // Idle flag and sticky overflow.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      cas_idle <= 1'b1;
      overflow <= 1'b0;
    end else begin
      cas_idle <= (state_n == ST_IDLE) && (count_n == '0);
      if (bus.act_valid && !bus.act_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cas_scheduler.sv
// Directed bench for cas_scheduler: hand-computed CAS cycles for single,
// back-to-back, turnaround, full/backpressure and mid-operation reset cases.
module tb_cas_scheduler;
  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;

  logic       clk;
  logic       reset;
  logic [7:0] t_ccd, cl, cwl, bl;
  logic       cas_idle, overflow;
  logic [1:0] state_dbg;

  cas_scheduler_if #(.ADDR_W(14)) bus ();

  cas_scheduler #(
    .DEPTH(8), .CNT_W(8), .ADDR_W(14), .TRCD(11), .TWTR(6)
  ) dut (
    .clock_t   (clk),
    .reset     (reset),
    .bus       (bus),
    .tCCD      (t_ccd),
    .CL        (cl),
    .CWL       (cwl),
    .BL        (bl),
    .cas_idle  (cas_idle),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  // scoreboard: {cycle[15:0], rw, addr}
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_vld[$];
  logic [31:0] vld_q[$];

  function automatic logic [31:0] mk(int c, logic [1:0] rw, logic [13:0] a);
    return {c[15:0], rw, a};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.cas_valid) vld_q.push_back(32'(cyc));
    if (bus.cas_valid && bus.cas_ready) got_q.push_back({cyc[15:0], bus.cas_rw, bus.cas_addr});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic act(logic [1:0] rw, logic [13:0] a);
    bus.act_valid = 1'b1;
    bus.act_rw    = rw;
    bus.act_addr  = a;
    tick();
    bus.act_valid = 1'b0;
  endtask

  task automatic check_hs(string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({tag, "_cas"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_vld(string tag);
    check({tag, "_vcount"}, 32'(vld_q.size()), 32'(exp_vld.size()));
    for (int i = 0; i < exp_vld.size(); i++)
      if (i < vld_q.size()) check({tag, "_vcyc"}, vld_q[i], exp_vld[i]);
    vld_q.delete();
    exp_vld.delete();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_act_ready"}, 32'(bus.act_ready), 32'd1);
    check({tag, "_cas_valid"}, 32'(bus.cas_valid), 32'd0);
    check({tag, "_cas_rw"},    32'(bus.cas_rw),    32'(RD));
    check({tag, "_cas_addr"},  32'(bus.cas_addr),  32'd0);
    check({tag, "_idle"},      32'(cas_idle),      32'd1);
    check({tag, "_overflow"},  32'(overflow),      32'd0);
    check({tag, "_state"},     32'(state_dbg),     32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.act_valid = 1'b0;
    bus.act_rw    = RD;
    bus.act_addr  = '0;
    bus.cas_ready = 1'b1;
    t_ccd = 8'd4;
    cl    = 8'd11;
    cwl   = 8'd9;
    bl    = 8'd8;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("reset");
    repeat (2) tick();

    // single READ: CAS exactly in cycle 11, idle again by cycle 13
    base = cyc;
    act(RD, 14'h123);
    check("single_idle_fall", 32'(cas_idle), 32'd0);
    repeat (10) tick();
    check("single_state_issue", 32'(state_dbg), 32'd2);
    repeat (2) tick();
    check("single_idle_back", 32'(cas_idle), 32'd1);
    repeat (25) tick();
    exp_q.push_back(mk(base + 11, RD, 14'h123));
    exp_vld.push_back(32'(base + 11));
    check_hs("single");
    check_vld("single");

    // back-to-back READs, tCCD=4
    base = cyc;
    act(RD, 14'h010);
    act(RD, 14'h011);
    repeat (38) tick();
    exp_q.push_back(mk(base + 11, RD, 14'h010));
    exp_q.push_back(mk(base + 15, RD, 14'h011));
    exp_vld.push_back(32'(base + 11));
    exp_vld.push_back(32'(base + 15));
    check_hs("rd_rd");
    check_vld("rd_rd");

    // READ -> WRITE: gap = 11-9+4+2 = 8
    base = cyc;
    act(RD, 14'h200);
    act(WR, 14'h201);
    repeat (38) tick();
    exp_q.push_back(mk(base + 11, RD, 14'h200));
    exp_q.push_back(mk(base + 19, WR, 14'h201));
    exp_vld.push_back(32'(base + 11));
    exp_vld.push_back(32'(base + 19));
    check_hs("rd_wr");
    check_vld("rd_wr");

    // WRITE -> READ: gap = 9+4+6 = 19
    base = cyc;
    act(WR, 14'h2A0);
    act(RD, 14'h2A1);
    repeat (48) tick();
    exp_q.push_back(mk(base + 11, WR, 14'h2A0));
    exp_q.push_back(mk(base + 30, RD, 14'h2A1));
    exp_vld.push_back(32'(base + 11));
    exp_vld.push_back(32'(base + 30));
    check_hs("wr_rd");
    check_vld("wr_rd");

    // full FIFO with downstream stalled, 9th ACT dropped
    bus.cas_ready = 1'b0;
    base = cyc;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) check("full_ready_before", 32'(bus.act_ready), 32'd1);
      if (i == 8) check("full_ready_low", 32'(bus.act_ready), 32'd0);
      act(RD, 14'(14'h300 + i));
    end
    check("full_overflow", 32'(overflow), 32'd1);
    while (cyc < base + 20) tick();
    check("stall_valid", 32'(bus.cas_valid), 32'd1);
    check("stall_addr", 32'(bus.cas_addr), 32'h300);
    while (cyc < base + 40) tick();
    bus.cas_ready = 1'b1;
    repeat (45) tick();
    for (int i = 0; i < 8; i++)
      exp_q.push_back(mk(base + 40 + 4 * i, RD, 14'(14'h300 + i)));
    check_hs("full");
    check("full_overflow_sticky", 32'(overflow), 32'd1);
    check("full_idle", 32'(cas_idle), 32'd1);
    vld_q.delete();

    // reset mid-operation: queued entries discarded, fresh ACT at cycle 7
    base = cyc;
    act(RD, 14'h0A0);
    act(WR, 14'h0A1);
    act(RD, 14'h0A2);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midreset");
    tick();
    act(RD, 14'h0AB);
    repeat (30) tick();
    exp_q.push_back(mk(base + 18, RD, 14'h0AB));
    exp_vld.push_back(32'(base + 18));
    check_hs("after_reset");
    check_vld("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
